v5c_config_ctrl: RTL and testbench
==================================

Name: v5c_config_ctrl

Overview:
- Sequences slave-serial configuration of the Virtex-5: pulses PROG_B, waits for INIT_B, then serialises host-supplied bytes onto DIN with a generated CCLK. Finishes by clocking until DONE rises.
- Drives the CCLK output-enable/data pins of the V5 pad buffers and samples the buffered INIT_B input.
- Sits between the CPLD host-side bitstream source (byte stream) and the V5 pad buffers.

Parameters:
- CLK_DIV, 2, clk cycles per CCLK half-period (>=1).
- PROG_CYCLES, 16, clk cycles PROG_B is held low.
- INIT_TIMEOUT, 65535, max clk cycles waiting for each INIT_B edge.
- DONE_CLKS, 1024, max extra CCLK periods after last byte while waiting for DONE.
- TIMER_W, 16, width of shared timer (must hold all above values).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins configuration from IDLE/DONE/ERROR
- abort  in  1  level; forces ERROR from any active state
- data  in  8  bitstream byte, MSB shifted first
- data_valid  in  1  byte available
- data_last  in  1  qualifies final byte with data_valid
- data_ready  out  1  byte accepted when data_valid & data_ready
- v5c_prog_n  out  1  PROG_B drive (active low)
- v5c_init_n_o  in  1  INIT_B from input buffer (asynchronous)
- v5c_done  in  1  DONE pin (asynchronous)
- v5c_cclk_i  out  1  CCLK value to output buffer
- v5c_cclk_oe  out  1  CCLK output enable
- v5c_din  out  1  serial data to V5 DIN
- busy  out  1  high in any state except IDLE/DONE/ERROR
- cfg_done  out  1  high in DONE state
- cfg_err  out  1  high in ERROR state
- err_code  out  2  0 none, 1 INIT timeout, 2 INIT low during load (CRC), 3 DONE timeout/abort

Behaviour:
- Reset values: v5c_prog_n=1, v5c_cclk_i=0, v5c_cclk_oe=0, v5c_din=0, data_ready=0, busy=0, cfg_done=0, cfg_err=0, err_code=0; state IDLE.
- v5c_init_n_o and v5c_done pass through 2-flop synchronisers; all decisions use synchronised values (2-cycle latency).
- States: IDLE, PROG, WAIT_INIT_LO, WAIT_INIT_HI, LOAD, SHIFT, FLUSH, DONE, ERROR.
- IDLE/DONE/ERROR: start -> PROG. Timer cleared and err_code cleared on entry to PROG.
- PROG: prog_n=0 for exactly PROG_CYCLES cycles, then prog_n=1 -> WAIT_INIT_LO.
- WAIT_INIT_LO: init sync low -> WAIT_INIT_HI; timer reaches INIT_TIMEOUT -> ERROR code 1.
- WAIT_INIT_HI: init sync high -> LOAD, cclk_oe=1 from this transition until DONE/ERROR; timeout -> ERROR code 1.
- LOAD: data_ready=1; on handshake latch byte and last flag -> SHIFT. data_ready is combinational on state only (not on data_valid).
- SHIFT: 8 bits, MSB first. Per bit: din updated and cclk_i=0 for CLK_DIV cycles, then cclk_i=1 for CLK_DIV cycles. Byte takes 16*CLK_DIV cycles at CLK_DIV=1 minimum 16. After bit 0 high phase: last -> FLUSH, else LOAD. No CCLK toggles while in LOAD (stall holds cclk_i=0).
- init sync low at any cycle in LOAD/SHIFT/FLUSH -> ERROR code 2.
- FLUSH: keeps toggling CCLK (din=1) with the same duty; done sync high -> complete current CCLK period, then DONE. After DONE_CLKS periods without DONE -> ERROR code 3.
- DONE/ERROR: cclk_oe=0, cclk_i=0, prog_n=1; status held until next start.
- abort in any busy state -> ERROR code 3 next cycle; abort in IDLE/DONE/ERROR ignored. abort has priority over start and all other transitions in the same cycle.
- start while busy ignored. reset_n low mid-operation returns all outputs to reset values immediately (asynchronous); prog_n releases high.

Decomposition:
- Package v5c_config_pkg: state encoding constants, err_code constants (ERR_NONE, ERR_INIT_TO, ERR_CRC, ERR_DONE).
- One sub-module: v5c_config_shifter (byte latch, bit counter, CCLK half-period divider, din/cclk generation; go/byte_done handshake with the FSM).

Test Plan:
- Normal: start, model drives INIT low 10 cycles after prog_n rises, high 20 later; stream 4 bytes 0xAA,0x99,0x55,0x66 (last on 0x66); DONE high after 8 flush CCLKs -> din matches MSB-first bits on each cclk rising edge, 32+ rising edges, cfg_done=1, err_code=0.
- PROG width: CLK_DIV=2, PROG_CYCLES=16 -> prog_n low exactly 16 cycles.
- INIT timeout: INIT_TIMEOUT=100, INIT never goes low -> cfg_err=1, err_code=1 at cycle ~100 after prog release, cclk_oe=0.
- CRC: drive INIT low during byte 2 -> ERROR code 2 within 3 cycles, CCLK stops.
- Stall: deassert data_valid 50 cycles between bytes -> cclk_i held 0, no extra edges, bit sequence intact.
- Abort/reset: abort mid-SHIFT -> err_code=3; reset_n low mid-FLUSH -> all outputs at reset values asynchronously; subsequent start completes normally.

Source files
------------

// File: rtl/v5c_config_pkg.sv
// Shared types and constants for the Virtex-5 slave-serial configuration controller.
// Imported by the sequencer and its shifter.
package v5c_config_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PROG,
        ST_WAIT_INIT_LO,
        ST_WAIT_INIT_HI,
        ST_LOAD,
        ST_SHIFT,
        ST_FLUSH,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_INIT_TO = 2'd1;
    localparam logic [1:0] ERR_CRC     = 2'd2;
    localparam logic [1:0] ERR_DONE    = 2'd3;

    localparam int BYTE_BITS = 8;

    function automatic logic is_busy(input state_t s);
        return !(s inside {ST_IDLE, ST_DONE, ST_ERROR});
    endfunction

endpackage

// File: rtl/v5c_config_shifter.sv
// Byte latch, bit counter and CCLK half-period divider.
// Serialises a byte MSB first, or free-runs CCLK with DIN high while flushing.
module v5c_config_shifter
    import v5c_config_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       last_in,
    input  logic       shift_en,
    input  logic       flush_en,
    output logic       byte_done,
    output logic       period_done,
    output logic       last,
    output logic       cclk,
    output logic       din
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [2:0] BIT_LAST = 3'(BYTE_BITS - 1);

    logic [DW-1:0] div_cnt;
    logic          phase;
    logic [2:0]    bit_cnt;
    logic [7:0]    sreg;
    logic          active;
    logic          half_end;

    assign active   = shift_en | flush_en;
    assign half_end = active && (div_cnt == DIV_LAST);

    // Divider/phase/bit counters; counters idle at zero so CCLK parks low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            sreg    <= '0;
            last    <= 1'b0;
        end else if (load) begin
            sreg    <= data;
            last    <= last_in;
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
        end else if (!active) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
        end else if (half_end) begin
            div_cnt <= '0;
            phase   <= ~phase;
            if (phase && shift_en) begin
                sreg    <= {sreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign byte_done   = shift_en && half_end && phase && (bit_cnt == BIT_LAST);
    assign period_done = flush_en && half_end && phase;
    assign cclk        = active & phase;
    assign din         = flush_en | (shift_en & sreg[7]);

endmodule

// File: rtl/v5c_config_ctrl.sv
// Slave-serial configuration sequencer for the Virtex-5: PROG_B pulse,
// INIT_B handshake, byte serialisation and DONE wait.
module v5c_config_ctrl
    import v5c_config_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int PROG_CYCLES  = 16,
    parameter int INIT_TIMEOUT = 65535,
    parameter int DONE_CLKS    = 1024,
    parameter int TIMER_W      = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] data,
    input  logic       data_valid,
    input  logic       data_last,
    output logic       data_ready,
    output logic       v5c_prog_n,
    input  logic       v5c_init_n_o,
    input  logic       v5c_done,
    output logic       v5c_cclk_i,
    output logic       v5c_cclk_oe,
    output logic       v5c_din,
    output logic       busy,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [1:0] err_code
);

    localparam logic [TIMER_W-1:0] PROG_LAST = TIMER_W'(PROG_CYCLES - 1);
    localparam logic [TIMER_W-1:0] INIT_LAST = TIMER_W'(INIT_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] DONE_LAST = TIMER_W'(DONE_CLKS - 1);

    state_t             state_q;
    state_t             state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [1:0]         err_q;
    logic [1:0]         err_d;
    logic [1:0]         init_sync;
    logic [1:0]         done_sync;
    logic               init_s;
    logic               done_s;
    logic               done_seen_q;
    logic               load;
    logic               shift_en;
    logic               flush_en;
    logic               byte_done;
    logic               period_done;
    logic               sh_last;

    // Two-flop synchronisers for the asynchronous INIT_B and DONE pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_sync <= 2'b11;
            done_sync <= 2'b00;
        end else begin
            init_sync <= {init_sync[0], v5c_init_n_o};
            done_sync <= {done_sync[0], v5c_done};
        end
    end

    assign init_s = init_sync[1];
    assign done_s = done_sync[1];

    // State and error-code registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Shared timer: restarts on every state change; counts CCLK periods in FLUSH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else if (state_d != state_q) begin
            timer_q <= '0;
        end else if (state_q == ST_FLUSH) begin
            if (period_done) begin
                timer_q <= timer_q + 1'b1;
            end
        end else if (is_busy(state_q)) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // Remember DONE seen mid-period so the running CCLK period can finish.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_seen_q <= 1'b0;
        end else if (state_q != ST_FLUSH) begin
            done_seen_q <= 1'b0;
        end else if (done_s) begin
            done_seen_q <= 1'b1;
        end
    end

    // Next-state and error-code selection; abort outranks everything.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        load    = 1'b0;
        if (abort && is_busy(state_q)) begin
            state_d = ST_ERROR;
            err_d   = ERR_DONE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_d = ST_PROG;
                        err_d   = ERR_NONE;
                    end
                end
                ST_PROG: begin
                    if (timer_q == PROG_LAST) begin
                        state_d = ST_WAIT_INIT_LO;
                    end
                end
                ST_WAIT_INIT_LO: begin
                    if (!init_s) begin
                        state_d = ST_WAIT_INIT_HI;
                    end else if (timer_q == INIT_LAST) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_INIT_TO;
                    end
                end
                ST_WAIT_INIT_HI: begin
                    if (init_s) begin
                        state_d = ST_LOAD;
                    end else if (timer_q == INIT_LAST) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_INIT_TO;
                    end
                end
                ST_LOAD: begin
                    if (!init_s) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CRC;
                    end else if (data_valid) begin
                        load    = 1'b1;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!init_s) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CRC;
                    end else if (byte_done) begin
                        state_d = sh_last ? ST_FLUSH : ST_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (!init_s) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CRC;
                    end else if (period_done) begin
                        if (done_seen_q || done_s) begin
                            state_d = ST_DONE;
                        end else if (timer_q == DONE_LAST) begin
                            state_d = ST_ERROR;
                            err_d   = ERR_DONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign shift_en = (state_q == ST_SHIFT);
    assign flush_en = (state_q == ST_FLUSH);

    v5c_config_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .data       (data),
        .last_in    (data_last),
        .shift_en   (shift_en),
        .flush_en   (flush_en),
        .byte_done  (byte_done),
        .period_done(period_done),
        .last       (sh_last),
        .cclk       (v5c_cclk_i),
        .din        (v5c_din)
    );

    assign v5c_prog_n  = (state_q != ST_PROG);
    assign v5c_cclk_oe = state_q inside {ST_LOAD, ST_SHIFT, ST_FLUSH};
    assign data_ready  = (state_q == ST_LOAD);
    assign busy        = is_busy(state_q);
    assign cfg_done    = (state_q == ST_DONE);
    assign cfg_err     = (state_q == ST_ERROR);
    assign err_code    = err_q;

endmodule

// File: tb/tb_v5c_config_ctrl.sv
// Self-checking bench for v5c_config_ctrl with a small V5 pin model
// and a CCLK-edge capture of DIN.
module tb_v5c_config_ctrl;

    localparam int CLK_DIV      = 2;
    localparam int PROG_CYCLES  = 16;
    localparam int INIT_TIMEOUT = 100;
    localparam int DONE_CLKS    = 16;
    localparam int TIMER_W      = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] data = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_last = 1'b0;
    logic       data_ready;
    logic       v5c_prog_n;
    logic       v5c_init_n_o = 1'b1;
    logic       v5c_done = 1'b0;
    logic       v5c_cclk_i;
    logic       v5c_cclk_oe;
    logic       v5c_din;
    logic       busy;
    logic       cfg_done;
    logic       cfg_err;
    logic [1:0] err_code;

    int   vectors = 0;
    int   miscompares = 0;
    int   base = 0;
    logic cap[$];
    logic prev_cclk = 1'b0;

    always #5 clk = ~clk;

    v5c_config_ctrl #(
        .CLK_DIV     (CLK_DIV),
        .PROG_CYCLES (PROG_CYCLES),
        .INIT_TIMEOUT(INIT_TIMEOUT),
        .DONE_CLKS   (DONE_CLKS),
        .TIMER_W     (TIMER_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .data        (data),
        .data_valid  (data_valid),
        .data_last   (data_last),
        .data_ready  (data_ready),
        .v5c_prog_n  (v5c_prog_n),
        .v5c_init_n_o(v5c_init_n_o),
        .v5c_done    (v5c_done),
        .v5c_cclk_i  (v5c_cclk_i),
        .v5c_cclk_oe (v5c_cclk_oe),
        .v5c_din     (v5c_din),
        .busy        (busy),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .err_code    (err_code)
    );

    // The V5 samples DIN on each CCLK rising edge.
    always @(negedge clk) begin
        if (v5c_cclk_i === 1'b1 && prev_cclk !== 1'b1) cap.push_back(v5c_din);
        prev_cclk = v5c_cclk_i;
    end

    task automatic begin_cfg(input int lo_dly, input int hi_dly,
                             output int pw, output bit ok);
        int n;
        pw = 0;
        ok = 1'b1;
        n = 0;
        v5c_done = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        while (v5c_prog_n === 1'b0 && n < 1000) begin
            pw++; n++;
            @(negedge clk);
        end
        if (lo_dly < 0) return;
        repeat (lo_dly) @(negedge clk);
        v5c_init_n_o = 1'b0;
        if (hi_dly < 0) return;
        repeat (hi_dly) @(negedge clk);
        v5c_init_n_o = 1'b1;
        n = 0;
        while (data_ready !== 1'b1 && n < 2000) begin
            @(negedge clk); n++;
        end
        ok = (data_ready === 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit lst,
                             input int gap, output bit ok);
        int n;
        n = 0;
        data_valid = 1'b0;
        repeat (gap) @(negedge clk);
        data = b;
        data_last = lst;
        data_valid = 1'b1;
        while (data_ready !== 1'b1 && n < 2000) begin
            @(negedge clk); n++;
        end
        ok = (data_ready === 1'b1);
        @(posedge clk); #1;
        data_valid = 1'b0;
        data_last = 1'b0;
    endtask

    task automatic wait_edges(input int target);
        int n;
        n = 0;
        while (cap.size() < target && n < 5000) begin
            @(negedge clk); n++;
        end
    endtask

    task automatic wait_end(input int lim, output int n);
        n = 0;
        while (!(cfg_done === 1'b1 || cfg_err === 1'b1) && n < lim) begin
            @(negedge clk); n++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({v5c_prog_n, v5c_cclk_i, v5c_cclk_oe, v5c_din, data_ready,
             busy, cfg_done, cfg_err, err_code} !== 10'b1000000000) begin
            miscompares++;
            $display("FAIL reset_outs got=%b exp=%b",
                {v5c_prog_n, v5c_cclk_i, v5c_cclk_oe, v5c_din, data_ready,
                 busy, cfg_done, cfg_err, err_code}, 10'b1000000000);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, v5c_prog_n} !== 2'b01) begin
            miscompares++;
            $display("FAIL idle_after_reset got=%b exp=01", {busy, v5c_prog_n});
        end
    endtask

    task automatic test_normal();
        logic [7:0] bytes [4];
        logic exp[$];
        logic got;
        int pw, n, nf;
        bit ok;
        bytes = '{8'hAA, 8'h99, 8'h55, 8'h66};
        for (int i = 0; i < 4; i++)
            for (int b = 7; b >= 0; b--) exp.push_back(bytes[i][b]);
        base = cap.size();
        begin_cfg(10, 20, pw, ok);
        vectors++;
        if (pw != PROG_CYCLES) begin
            miscompares++;
            $display("FAIL prog_width got=%0d exp=%0d", pw, PROG_CYCLES);
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL reach_load got=0 exp=1");
        end
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i], i == 3, 0, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL normal_handshake byte=%0d got=0 exp=1", i);
            end
        end
        wait_edges(base + 40);
        v5c_done = 1'b1;
        wait_end(500, n);
        vectors++;
        if (cfg_done !== 1'b1 || err_code !== 2'd0) begin
            miscompares++;
            $display("FAIL normal_done got=%b/%0d exp=1/0", cfg_done, err_code);
        end
        nf = cap.size() - base - 32;
        vectors++;
        if (nf < 9 || nf > 10) begin
            miscompares++;
            $display("FAIL normal_flush_edges got=%0d exp=9..10", nf);
        end
        for (int i = 0; i < 32; i++) begin
            got = (base + i < cap.size()) ? cap[base + i] : 1'bx;
            vectors++;
            if (got !== exp[i]) begin
                miscompares++;
                $display("FAIL normal_bit %0d got=%b exp=%b", i, got, exp[i]);
            end
        end
        for (int i = base + 32; i < cap.size(); i++) begin
            vectors++;
            if (cap[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL flush_din edge=%0d got=%b exp=1", i - base, cap[i]);
            end
        end
        vectors++;
        if ({v5c_cclk_oe, v5c_cclk_i, busy, v5c_prog_n} !== 4'b0001) begin
            miscompares++;
            $display("FAIL done_pins got=%b exp=0001",
                {v5c_cclk_oe, v5c_cclk_i, busy, v5c_prog_n});
        end
        abort = 1'b1;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if ({cfg_done, cfg_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL abort_in_done got=%b exp=10", {cfg_done, cfg_err});
        end
    endtask

    task automatic test_init_timeout();
        int pw, n;
        bit ok;
        begin_cfg(-1, -1, pw, ok);
        n = 0;
        while (cfg_err !== 1'b1 && n < 300) begin
            @(negedge clk); n++;
        end
        vectors++;
        if (n < INIT_TIMEOUT - 2 || n > INIT_TIMEOUT + 2) begin
            miscompares++;
            $display("FAIL init_lo_timeout_cycles got=%0d exp=%0d", n, INIT_TIMEOUT);
        end
        vectors++;
        if ({err_code, v5c_cclk_oe, v5c_prog_n} !== 4'b0101) begin
            miscompares++;
            $display("FAIL init_lo_timeout_pins got=%b exp=0101",
                {err_code, v5c_cclk_oe, v5c_prog_n});
        end
        begin_cfg(5, -1, pw, ok);
        vectors++;
        if ({cfg_err, err_code} !== 3'b000) begin
            miscompares++;
            $display("FAIL err_cleared_on_start got=%b exp=000", {cfg_err, err_code});
        end
        wait_end(400, n);
        vectors++;
        if (cfg_err !== 1'b1 || err_code !== 2'd1) begin
            miscompares++;
            $display("FAIL init_hi_timeout got=%b/%0d exp=1/1", cfg_err, err_code);
        end
        v5c_init_n_o = 1'b1;
    endtask

    task automatic test_crc();
        logic [7:0] b0, b1;
        int pw, n, sz;
        bit ok;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        base = cap.size();
        begin_cfg(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)), pw, ok);
        send_byte(b0, 1'b0, 0, ok);
        send_byte(b1, 1'b0, 0, ok);
        wait_edges(base + 11);
        v5c_init_n_o = 1'b0;
        n = 0;
        while (cfg_err !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        vectors++;
        if (n > 3) begin
            miscompares++;
            $display("FAIL crc_latency got=%0d exp<=3", n);
        end
        vectors++;
        if (err_code !== 2'd2) begin
            miscompares++;
            $display("FAIL crc_code got=%0d exp=2", err_code);
        end
        sz = cap.size();
        repeat (20) @(negedge clk);
        vectors++;
        if (cap.size() != sz || v5c_cclk_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL crc_cclk_stop got=%0d/%b exp=%0d/0",
                cap.size(), v5c_cclk_oe, sz);
        end
        v5c_init_n_o = 1'b1;
    endtask

    task automatic test_stall();
        logic [7:0] bytes [3];
        logic exp[$];
        logic got;
        int pw, n, viol;
        bit ok;
        for (int i = 0; i < 3; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 3; i++)
            for (int b = 7; b >= 0; b--) exp.push_back(bytes[i][b]);
        base = cap.size();
        begin_cfg(3, 4, pw, ok);
        send_byte(bytes[0], 1'b0, 0, ok);
        viol = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (c >= 40 && v5c_cclk_i !== 1'b0) viol++;
        end
        vectors++;
        if (viol != 0) begin
            miscompares++;
            $display("FAIL stall_cclk_low got=%0d exp=0", viol);
        end
        vectors++;
        if (cap.size() - base != 8) begin
            miscompares++;
            $display("FAIL stall_edges got=%0d exp=8", cap.size() - base);
        end
        send_byte(bytes[1], 1'b0, 0, ok);
        send_byte(bytes[2], 1'b1, 50, ok);
        wait_edges(base + 26);
        v5c_done = 1'b1;
        wait_end(500, n);
        vectors++;
        if (cfg_done !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_done got=%b exp=1", cfg_done);
        end
        for (int i = 0; i < 24; i++) begin
            got = (base + i < cap.size()) ? cap[base + i] : 1'bx;
            vectors++;
            if (got !== exp[i]) begin
                miscompares++;
                $display("FAIL stall_bit %0d got=%b exp=%b", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] b0;
        int pw, n;
        bit ok;
        b0 = 8'($urandom);
        base = cap.size();
        begin_cfg(2, 2, pw, ok);
        send_byte(b0, 1'b0, 0, ok);
        wait_edges(base + 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, v5c_prog_n} !== 2'b11) begin
            miscompares++;
            $display("FAIL start_while_busy got=%b exp=11", {busy, v5c_prog_n});
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (cfg_err !== 1'b1 || err_code !== 2'd3) begin
            miscompares++;
            $display("FAIL abort_code got=%b/%0d exp=1/3", cfg_err, err_code);
        end
        vectors++;
        if ({v5c_cclk_i, v5c_cclk_oe, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_pins got=%b exp=000", {v5c_cclk_i, v5c_cclk_oe, busy});
        end
        n = cap.size() - base;
        for (int i = 0; i < n && i < 8; i++) begin
            vectors++;
            if (cap[base + i] !== b0[7 - i]) begin
                miscompares++;
                $display("FAIL abort_bit %0d got=%b exp=%b", i, cap[base + i], b0[7 - i]);
            end
        end
    endtask

    task automatic test_done_timeout();
        logic [7:0] b0;
        int pw, n;
        bit ok;
        b0 = 8'($urandom);
        base = cap.size();
        begin_cfg(4, 6, pw, ok);
        send_byte(b0, 1'b1, 0, ok);
        wait_end(1000, n);
        vectors++;
        if (cfg_err !== 1'b1 || err_code !== 2'd3) begin
            miscompares++;
            $display("FAIL done_timeout_code got=%b/%0d exp=1/3", cfg_err, err_code);
        end
        vectors++;
        if (cap.size() - base - 8 != DONE_CLKS) begin
            miscompares++;
            $display("FAIL done_timeout_periods got=%0d exp=%0d",
                cap.size() - base - 8, DONE_CLKS);
        end
    endtask

    task automatic test_reset_flush();
        int pw;
        bit ok;
        base = cap.size();
        begin_cfg(5, 5, pw, ok);
        send_byte(8'($urandom), 1'b0, 0, ok);
        send_byte(8'($urandom), 1'b1, 0, ok);
        wait_edges(base + 19);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({v5c_prog_n, v5c_cclk_i, v5c_cclk_oe, v5c_din, data_ready,
             busy, cfg_done, cfg_err, err_code} !== 10'b1000000000) begin
            miscompares++;
            $display("FAIL async_reset_outs got=%b exp=%b",
                {v5c_prog_n, v5c_cclk_i, v5c_cclk_oe, v5c_din, data_ready,
                 busy, cfg_done, cfg_err, err_code}, 10'b1000000000);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random(input int runs);
        logic [7:0] bytes[$];
        logic exp[$];
        logic got;
        int nb, k, pw, n, nf;
        bit ok;
        for (int r = 0; r < runs; r++) begin
            bytes.delete();
            exp.delete();
            nb = int'($urandom_range(1, 6));
            k = int'($urandom_range(0, 5));
            for (int i = 0; i < nb; i++) bytes.push_back(8'($urandom));
            for (int i = 0; i < nb; i++)
                for (int b = 7; b >= 0; b--) exp.push_back(bytes[i][b]);
            base = cap.size();
            begin_cfg(int'($urandom_range(1, 30)), int'($urandom_range(1, 30)), pw, ok);
            vectors++;
            if (pw != PROG_CYCLES || !ok) begin
                miscompares++;
                $display("FAIL rand_prog run=%0d got=%0d/%b exp=%0d/1", r, pw, ok, PROG_CYCLES);
            end
            for (int i = 0; i < nb; i++) begin
                send_byte(bytes[i], i == nb - 1, int'($urandom_range(0, 6)), ok);
                vectors++;
                if (!ok) begin
                    miscompares++;
                    $display("FAIL rand_handshake run=%0d byte=%0d got=0 exp=1", r, i);
                end
            end
            wait_edges(base + 8 * nb + k);
            v5c_done = 1'b1;
            wait_end(500, n);
            vectors++;
            if (cfg_done !== 1'b1 || err_code !== 2'd0) begin
                miscompares++;
                $display("FAIL rand_done run=%0d got=%b/%0d exp=1/0", r, cfg_done, err_code);
            end
            nf = cap.size() - base - 8 * nb;
            vectors++;
            if (nf < k + 1 || nf > k + 2) begin
                miscompares++;
                $display("FAIL rand_flush run=%0d got=%0d exp=%0d..%0d", r, nf, k + 1, k + 2);
            end
            for (int i = 0; i < 8 * nb; i++) begin
                got = (base + i < cap.size()) ? cap[base + i] : 1'bx;
                vectors++;
                if (got !== exp[i]) begin
                    miscompares++;
                    $display("FAIL rand_bit run=%0d bit=%0d got=%b exp=%b", r, i, got, exp[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_init_timeout();
        test_crc();
        test_stall();
        test_abort();
        test_done_timeout();
        test_reset_flush();
        test_random(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
